// File: rtl/interrupt_controller_pkg.sv
// Shared types and widths for the interrupt controller.
// No logic; the fetch PC width and the controller state encoding live here.
// No flow control.
package interrupt_controller_pkg;

    localparam int PC_SIZE = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any bit is set and the lowest set index.
// Combinational, zero latency.
// No flow control.
module irq_priority_encoder #(
    parameter  int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    output logic         vld,
    output logic [W-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Latches irq rising edges, arbitrates masked pending lines, and hands one vector at a time to fetch.
// Latency: irq rise to int_req is 2 cycles; all outputs registered.
// Backpressure: int_req is held until int_ack; later edges wait in pending until int_ret.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter  int NUM_IRQ       = 4,
    parameter  int VECTOR_BASE   = 'hE0,
    parameter  int VECTOR_STRIDE = 4,
    localparam int ID_W          = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic [PC_SIZE-1:0] pc,
    output logic               int_req,
    output logic [PC_SIZE-1:0] int_vector,
    output logic [ID_W-1:0]    active_id,
    input  logic               int_ack,
    input  logic               int_ret,
    output logic [PC_SIZE-1:0] ret_pc,
    output logic               in_service
);

    localparam logic [PC_SIZE-1:0] RESET_VECTOR = PC_SIZE'(VECTOR_BASE);

    irq_state_t         state;
    logic [NUM_IRQ-1:0] irq_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] irq_edge;
    logic [NUM_IRQ-1:0] ack_clr;
    logic               win_vld;
    logic [ID_W-1:0]    win_id;
    logic               ack_take;

    // Handler address wraps at the PC width.
    function automatic logic [PC_SIZE-1:0] vector_of(input logic [ID_W-1:0] id);
        int v;
        v = VECTOR_BASE + int'(id) * VECTOR_STRIDE;
        return v[PC_SIZE-1:0];
    endfunction

    assign irq_edge = irq & ~irq_q;
    assign ack_take = (state == REQUEST) && int_ack;
    assign ack_clr  = ack_take ? (NUM_IRQ'(1) << active_id) : '0;

    irq_priority_encoder #(.N(NUM_IRQ)) u_prio (
        .req (pending & irq_mask),
        .vld (win_vld),
        .idx (win_id)
    );

    // A new edge on the line being acked re-arms it rather than being lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq;
            pending <= (pending & ~ack_clr) | irq_edge;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_vector <= RESET_VECTOR;
            active_id  <= '0;
            ret_pc     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state      <= REQUEST;
                        int_req    <= 1'b1;
                        active_id  <= win_id;
                        int_vector <= vector_of(win_id);
                    end
                end
                REQUEST: begin
                    if (int_ack) begin
                        state      <= SERVICE;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                        ret_pc     <= pc;
                    end
                end
                SERVICE: begin
                    if (int_ret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with PC width 8 and default vector layout.
module tb_interrupt_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] irq;
    logic [3:0] irq_mask;
    logic [7:0] pc;
    logic       int_req;
    logic [7:0] int_vector;
    logic [1:0] active_id;
    logic       int_ack;
    logic       int_ret;
    logic [7:0] ret_pc;
    logic       in_service;

    int checks   = 0;
    int failures = 0;

    interrupt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .irq_mask   (irq_mask),
        .pc         (pc),
        .int_req    (int_req),
        .int_vector (int_vector),
        .active_id  (active_id),
        .int_ack    (int_ack),
        .int_ret    (int_ret),
        .ret_pc     (ret_pc),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req"}, 32'(int_req), 32'h0);
        chk({tag, "_vec"}, 32'(int_vector), 32'hE0);
        chk({tag, "_id"}, 32'(active_id), 32'h0);
        chk({tag, "_retpc"}, 32'(ret_pc), 32'h0);
        chk({tag, "_insvc"}, 32'(in_service), 32'h0);
    endtask

    // Ack the outstanding request at the given pc, then return from the handler.
    task automatic ack_and_return(input logic [7:0] at_pc);
        pc = at_pc; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq = '0; irq_mask = 4'hF; pc = '0; int_ack = 1'b0; int_ret = 1'b0;
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        chk("idle_no_req", 32'(int_req), 32'h0);

        // Single-cycle pulse on irq[2]: request two edges later.
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        chk("irq2_req_lat1", 32'(int_req), 32'h0);
        tick();
        chk("irq2_req", 32'(int_req), 32'h1);
        chk("irq2_vec", 32'(int_vector), 32'hE8);
        chk("irq2_id", 32'(active_id), 32'h2);
        pc = 8'h50; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("irq2_insvc", 32'(in_service), 32'h1);
        chk("irq2_req_drop", 32'(int_req), 32'h0);
        chk("irq2_retpc", 32'(ret_pc), 32'h50);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        chk("irq2_ret_idle", 32'(in_service), 32'h0);
        tick();
        chk("irq2_no_rereq", 32'(int_req), 32'h0);

        // Simultaneous irq[1] and irq[3]: lower index first.
        irq = 4'b1010;
        tick();
        irq = 4'b0000;
        tick();
        chk("pri_first_req", 32'(int_req), 32'h1);
        chk("pri_first_vec", 32'(int_vector), 32'hE4);
        chk("pri_first_id", 32'(active_id), 32'h1);
        pc = 8'h37; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("pri_retpc", 32'(ret_pc), 32'h37);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        chk("pri_idle_gap", 32'(int_req), 32'h0);
        tick();
        chk("pri_second_req", 32'(int_req), 32'h1);
        chk("pri_second_vec", 32'(int_vector), 32'hEC);
        chk("pri_second_id", 32'(active_id), 32'h3);
        ack_and_return(8'h40);
        tick();
        chk("pri_drained", 32'(int_req), 32'h0);

        // Masked line is held pending and fires once enabled.
        irq_mask = 4'b1110;
        irq = 4'b0001;
        tick();
        irq = 4'b0000;
        tick(9);
        chk("mask_hold_noreq", 32'(int_req), 32'h0);
        irq_mask = 4'hF;
        tick();
        chk("mask_release_req", 32'(int_req), 32'h1);
        chk("mask_release_vec", 32'(int_vector), 32'hE0);
        chk("mask_release_id", 32'(active_id), 32'h0);
        ack_and_return(8'h41);
        tick();

        // Re-edge and spurious ack during SERVICE of id 2.
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        tick();
        pc = 8'h10; int_ack = 1'b1;
        tick();
        pc = 8'hAA; irq = 4'b0100;
        tick();
        irq = 4'b0000; int_ack = 1'b0;
        tick();
        chk("svc_stays", 32'(in_service), 32'h1);
        chk("svc_no_req", 32'(int_req), 32'h0);
        chk("svc_retpc_kept", 32'(ret_pc), 32'h10);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        chk("svc_rereq", 32'(int_req), 32'h1);
        chk("svc_rereq_id", 32'(active_id), 32'h2);
        ack_and_return(8'h42);
        tick();

        // Edge on irq[1] in the ack cycle keeps it pending.
        irq = 4'b0010;
        tick();
        irq = 4'b0000;
        tick();
        chk("setwin_req", 32'(int_req), 32'h1);
        int_ack = 1'b1; irq = 4'b0010;
        tick();
        int_ack = 1'b0; irq = 4'b0000;
        chk("setwin_insvc", 32'(in_service), 32'h1);
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
        tick();
        chk("setwin_rereq", 32'(int_req), 32'h1);
        chk("setwin_rereq_id", 32'(active_id), 32'h1);
        ack_and_return(8'h43);
        tick();
        chk("setwin_drained", 32'(int_req), 32'h0);

        // Asynchronous reset during REQUEST.
        irq = 4'b1000;
        tick();
        irq = 4'b0000;
        tick();
        chk("arst_req_pre", 32'(int_req), 32'h1);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("arst_req");
        @(posedge clk); #1;
        rst = 1'b0;
        tick(2);
        chk("arst_req_dropped", 32'(int_req), 32'h0);

        // Asynchronous reset during SERVICE.
        irq = 4'b0100;
        tick();
        irq = 4'b0000;
        tick();
        pc = 8'h66; int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("arst_svc_pre", 32'(in_service), 32'h1);
        chk("arst_svc_retpc_pre", 32'(ret_pc), 32'h66);
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("arst_svc");

        // irq[0] held high across reset release counts as an edge.
        irq = 4'b0001;
        tick();
        rst = 1'b0;
        tick();
        chk("held_lat1", 32'(int_req), 32'h0);
        tick();
        chk("held_req", 32'(int_req), 32'h1);
        chk("held_id", 32'(active_id), 32'h0);
        chk("held_vec", 32'(int_vector), 32'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Collects external interrupt lines and presents one vectored request at a time to the fetch unit's interrupt port. Latches rising edges into pending bits, applies a mask and fixed priority, and runs a request/acknowledge handshake with the fetch unit. Saves the interrupted PC for return-from-interrupt. Sits directly upstream of the fetch unit, alongside the branch controller, in the single-cycle core.

## Interface

- NUM_IRQ, 4, number of interrupt lines (2..8)
- VECTOR_BASE, 'hE0, PC of the handler for irq 0
- VECTOR_STRIDE, 4, PC distance between consecutive handler entries

- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- irq  in  NUM_IRQ  external lines, synchronous to clk, edge-sensitive
- irq_mask  in  NUM_IRQ  1 = line enabled
- pc  in  `PC_SIZE  current fetch PC from the fetch unit
- int_req  out  1  vectored request to the fetch unit
- int_vector  out  `PC_SIZE  handler PC, valid while int_req=1
- active_id  out  $clog2(NUM_IRQ)  id being requested or serviced
- int_ack  in  1  fetch unit takes the vector this cycle
- int_ret  in  1  decoder reports a return-from-interrupt instruction
- ret_pc  out  `PC_SIZE  saved PC to resume at
- in_service  out  1  handler running

## Operation

- Edge detect: irq_q <= irq each cycle; edge[i] = irq[i] & ~irq_q[i]; pending[i] set on edge[i].
- Arbitration: candidates = pending & irq_mask; lowest index wins. Masked pending bits are held, not dropped.
- FSM states: IDLE, REQUEST, SERVICE.
  - IDLE: if candidates != 0, latch winner into active_id and go to REQUEST.
  - REQUEST: int_req=1, int_vector = VECTOR_BASE + active_id*VECTOR_STRIDE, modulo 2^`PC_SIZE. On int_ack: ret_pc <= pc, clear pending[active_id], go to SERVICE.
  - SERVICE: in_service=1. On int_ret, go to IDLE. No nesting.
- Once committed, a request is held: a mask change in REQUEST does not withdraw it.
- int_ack outside REQUEST is ignored. int_ret outside SERVICE is ignored.
- An edge on line i in the same cycle as its ack clears leaves pending[i]=1 (set wins).

## Timing

- Reset values: int_req=0, int_vector=VECTOR_BASE, active_id=0, ret_pc=0, in_service=0, pending=0, irq_q=0, state IDLE. Reset mid-operation discards any request or service immediately.
- Because irq_q resets to 0, a line held high across reset release counts as an edge on the first clock.
- Latency: irq rise sampled at edge n sets pending after n. State is REQUEST with int_req=1 after edge n+1, giving 2 cycles from irq to int_req.
- Ack at edge m: ret_pc holds pc as sampled at m. in_service=1 and int_req=0 after m.
- int_ret at edge k: IDLE after k. The next request can assert after edge k+1.
- All outputs are registered or decoded from registered state only. There is no combinational path from irq or int_ack to int_req.

## Structure

- The irq_state_t enum (IDLE/REQUEST/SERVICE) goes in nand_cpu.svh beside `PC_SIZE.
- Sub-module irq_priority_encoder: combinational, NUM_IRQ-bit vector in, valid + index out, lowest index wins.
- At top level, the block drives the fetch unit's interrupt_handler port. The decoder supplies int_ret.

## Test plan

All scenarios use PC_SIZE=8 and defaults.

- Reset, then pulse irq[2] for 1 cycle with mask='hF -> int_req=1 two cycles later, int_vector='hE8, active_id=2.
- irq[1] and irq[3] rise in the same cycle -> id 1 served first (vector 'hE4). After ack at pc='h37 and int_ret, id 3 is requested (vector 'hEC). ret_pc='h37 after the first ack.
- irq[0] rises with mask[0]=0 -> no int_req. Set mask[0]=1 10 cycles later -> int_req after 1 cycle, vector 'hE0.
- During SERVICE of id 2, irq[2] pulses again and int_ack is asserted spuriously -> in_service stays 1 and no request is made. After int_ret, id 2 is requested again.
- Edge on irq[1] in the same cycle as int_ack for id 1 -> pending[1] remains set. A second request for id 1 follows int_ret.
- Assert rst asynchronously during REQUEST and during SERVICE -> all outputs reach their reset values without a clock edge. irq[0] held high through reset release -> request for id 0 after release.
